pwm11_capture: RTL and testbench

- PWM decoder, the receive-side counterpart of the team's 11-bit PWM generator.
- Synchronizes an external PWM waveform, measures high time and period in clk cycles, and reports an 11-bit duty word with a one-cycle valid strobe.
- Used for loopback checking of motor-drive PWM and for reading PWM-output sensors.
- Detects stuck-high and stuck-low inputs via a timeout.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm11_capture_sync_edge_det.sv | 33 +++
 rtl/pwm11_capture.sv | 153 +++++++++++++++
 tb/tb_pwm11_capture.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the 11-bit PWM generator / capture pair.
package pwm_pkg;

    // Width of the duty word produced by the generator and reported by the capture block
    localparam int PWM_DUTY_W = 11;

    // Generator period in clocks (2^PWM_DUTY_W)
    localparam int PWM_PERIOD = 2048;

    // Capture FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/pwm11_capture_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus rise/fall detection
// against a one-cycle-delayed copy of the synchronized level.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    // Synchronizer chain and previous-level register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~prev_q;
    assign fall_o  = ~s2_q & prev_q;

endmodule

// File: rtl/pwm11_capture.sv
// PWM capture: measures high time and rising-to-rising period of an
// asynchronous PWM line in clk cycles and flags stuck lines via timeout.
module pwm11_capture
    import pwm_pkg::*;
#(
    parameter int DUTY_W  = PWM_DUTY_W,
    parameter int PER_W   = 13,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PWM_in,
    output logic [DUTY_W-1:0] duty,
    output logic [PER_W-1:0]  period,
    output logic              valid,
    output logic              timeout
);

    localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};
    // per_cnt value at which the next increment would reach TIMEOUT
    localparam logic [PER_W-1:0]  TO_LAST  = PER_W'(TIMEOUT - 1);

    logic level_s;
    logic rise_s;
    logic fall_s;
    logic to_hit_s;

    state_e            state_q,   state_d;
    logic [DUTY_W-1:0] hi_q,      hi_d;
    logic [PER_W-1:0]  per_q,     per_d;
    logic [DUTY_W-1:0] duty_q,    duty_d;
    logic [PER_W-1:0]  period_q,  period_d;
    logic              valid_q,   valid_d;
    logic              timeout_q, timeout_d;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (PWM_in),
        .level_o (level_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s)
    );

    // per_cnt doubles as the idle counter while in IDLE
    assign to_hit_s = (per_q == TO_LAST);

    // Next-state, counter and report logic; a rise always beats a timeout
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        per_d     = per_q;
        duty_d    = duty_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    // first rise only arms the measurement
                    hi_d    = DUTY_W'(1);
                    per_d   = PER_W'(1);
                    state_d = HIGH;
                end else if (to_hit_s) begin
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    period_d  = {PER_W{1'b0}};
                    duty_d    = level_s ? DUTY_MAX : {DUTY_W{1'b0}};
                    hi_d      = {DUTY_W{1'b0}};
                    per_d     = {PER_W{1'b0}};
                    state_d   = IDLE;
                end else begin
                    per_d = per_q + PER_W'(1);
                end
            end
            HIGH: begin
                if (to_hit_s) begin
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    period_d  = {PER_W{1'b0}};
                    duty_d    = level_s ? DUTY_MAX : {DUTY_W{1'b0}};
                    hi_d      = {DUTY_W{1'b0}};
                    per_d     = {PER_W{1'b0}};
                    state_d   = IDLE;
                end else begin
                    per_d = per_q + PER_W'(1);
                    if (fall_s) begin
                        // the fall cycle is already low: high time stays frozen
                        state_d = LOW;
                    end else if (hi_q != DUTY_MAX) begin
                        hi_d = hi_q + DUTY_W'(1);
                    end else begin
                        hi_d = hi_q;
                    end
                end
            end
            LOW: begin
                if (rise_s) begin
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    duty_d    = hi_q;
                    period_d  = per_q;
                    hi_d      = DUTY_W'(1);
                    per_d     = PER_W'(1);
                    state_d   = HIGH;
                end else if (to_hit_s) begin
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    period_d  = {PER_W{1'b0}};
                    duty_d    = level_s ? DUTY_MAX : {DUTY_W{1'b0}};
                    hi_d      = {DUTY_W{1'b0}};
                    per_d     = {PER_W{1'b0}};
                    state_d   = IDLE;
                end else begin
                    per_d = per_q + PER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hi_d    = {DUTY_W{1'b0}};
                per_d   = {PER_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered report outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hi_q      <= {DUTY_W{1'b0}};
            per_q     <= {PER_W{1'b0}};
            duty_q    <= {DUTY_W{1'b0}};
            period_q  <= {PER_W{1'b0}};
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            per_q     <= per_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign duty    = duty_q;
    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pwm11_capture.sv
// Directed bench for pwm11_capture: generator-style waveforms, stuck lines,
// mid-measurement reset, narrow pulses and report latency.
module tb_pwm11_capture;
    import pwm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PWM_in;
    logic [10:0] duty;
    logic [12:0] period;
    logic        valid;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nvalid = 0;
    int consec = 0;
    int any_valid_cyc = -10;
    int last_cyc = 0;
    int prev_cyc = 0;
    int rise_cyc = 0;
    int found;
    logic [10:0] l_duty;
    logic [12:0] l_per;
    logic        l_to;

    always #5 clk = ~clk;

    pwm11_capture dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .PWM_in  (PWM_in),
        .duty    (duty),
        .period  (period),
        .valid   (valid),
        .timeout (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock, sampled 1 time unit after the rising edge; records reports
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            if (any_valid_cyc == cyc - 1) consec++;
            any_valid_cyc = cyc;
            nvalid++;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            l_duty = duty;
            l_per  = period;
            l_to   = timeout;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic gen(input int hi, input int per, input int n);
        for (int p = 0; p < n; p++) begin
            PWM_in = 1'b1;
            rise_cyc = cyc;
            ticks(hi);
            PWM_in = 1'b0;
            ticks(per - hi);
        end
    endtask

    task automatic clr();
        nvalid = 0;
        last_cyc = 0;
        prev_cyc = 0;
    endtask

    initial begin
        rst_n  = 1'b0;
        PWM_in = 1'b0;
        ticks(3);
        chk("rst_duty", duty, 0);
        chk("rst_period", period, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        // duty 500: first rise arms, then one report per period
        clr();
        gen(500, PWM_PERIOD, 3);
        chk("d500_count", nvalid, 2);
        chk("d500_duty", l_duty, 500);
        chk("d500_period", l_per, 2048);
        chk("d500_timeout", l_to, 0);
        chk("d500_interval", last_cyc - prev_cyc, 2048);
        chk("d500_latency", last_cyc - rise_cyc, 3);

        // duty 2047 (one low clock per period)
        clr();
        gen(2047, PWM_PERIOD, 2);
        chk("d2047_duty", l_duty, 2047);
        chk("d2047_period", l_per, 2048);

        // duty changed to 1
        clr();
        gen(1, PWM_PERIOD, 2);
        chk("d1_duty", l_duty, 1);
        chk("d1_period", l_per, 2048);

        // line held low: repeating timeouts
        clr();
        PWM_in = 1'b0;
        ticks(3 * 4096 + 100);
        chk("low_count", nvalid, 3);
        chk("low_timeout", l_to, 1);
        chk("low_duty", l_duty, 0);
        chk("low_period", l_per, 0);
        chk("low_interval", last_cyc - prev_cyc, 4096);

        // line held high for 10000 clocks
        clr();
        PWM_in = 1'b1;
        ticks(10000);
        chk("high_count", nvalid, 2);
        chk("high_timeout", l_to, 1);
        chk("high_duty", l_duty, 2047);
        chk("high_period", l_per, 0);
        chk("high_interval", last_cyc - prev_cyc, 4096);

        // resume 100/300: one arming period, then a clean report
        clr();
        gen(100, 300, 3);
        chk("res_count", nvalid, 1);
        chk("res_duty", l_duty, 100);
        chk("res_period", l_per, 300);
        chk("res_timeout", l_to, 0);

        // asynchronous reset in the middle of a high phase
        PWM_in = 1'b1;
        ticks(20);
        rst_n = 1'b0;
        PWM_in = 1'b0;
        #1;
        chk("mid_rst_duty", duty, 0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_timeout", timeout, 0);
        ticks(3);
        rst_n = 1'b1;
        clr();
        gen(40, 100, 2);
        chk("post_rst_count", nvalid, 1);
        chk("post_rst_duty", l_duty, 40);
        chk("post_rst_period", l_per, 100);
        chk("post_rst_latency", last_cyc - rise_cyc, 3);

        // one-clock pulse every 50 clocks
        clr();
        gen(1, 50, 4);
        chk("pulse_count", nvalid, 4);
        chk("pulse_duty", l_duty, 1);
        chk("pulse_period", l_per, 50);
        chk("pulse_interval", last_cyc - prev_cyc, 50);

        // report latency from the closing rise, bounded wait
        ticks(10);
        clr();
        PWM_in = 1'b1;
        rise_cyc = cyc;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step();
            if (nvalid != 0) found = 1;
        end
        chk("lat_seen", found, 1);
        chk("lat_edges", last_cyc - rise_cyc, 3);
        chk("lat_duty", l_duty, 1);
        chk("lat_period", l_per, 60);

        chk("no_back_to_back_valid", consec, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
